// File: rtl/ram_ctrl_pkg.sv
// Shared widths, FSM state type and mem-side reset values for the RAM access sequencer.
package ram_ctrl_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 4;
  localparam int LEN_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

  // Idle RAM pins: disabled, read direction, zero address/data
  localparam logic              MEM_EN_RST    = 1'b0;
  localparam logic              MEM_RW_RST    = 1'b1;
  localparam logic [ADDR_W-1:0] MEM_ADDR_RST  = '0;
  localparam logic [DATA_W-1:0] MEM_WDATA_RST = '0;

endpackage

// File: rtl/burst_counter.sv
// Loadable burst address counter (wraps modulo 2^ADDR_W) with a beat counter flagging the final beat.
module burst_counter
  import ram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [LEN_W-1:0] beat;
  logic [LEN_W-1:0] len;

  // Address overflow past 63 simply wraps to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= MEM_ADDR_RST;
      beat <= '0;
      len  <= '0;
    end else if (load) begin
      addr <= load_addr;
      beat <= '0;
      len  <= load_len;
    end else if (advance) begin
      addr <= addr + 1'b1;
      beat <= beat + 1'b1;
    end
  end

  assign last = (beat == len);

endmodule

// File: rtl/ram_access_ctrl.sv
// Request-driven single/burst read and fill sequencer driving the 64x4 RAM pins,
// with a backpressured read response channel.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t state, state_nx;
  logic   accept;
  logic   cnt_adv;
  logic   cnt_last;

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // The counter's address register is the RAM address pin itself
  burst_counter u_burst_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .advance   (cnt_adv),
    .load_addr (req_addr),
    .load_len  (req_len),
    .addr      (mem_addr),
    .last      (cnt_last)
  );

  always_comb begin
    state_nx = state;
    cnt_adv  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nx = req_write ? WRITE : RD_ISSUE;
      end
      WRITE: begin
        if (cnt_last) state_nx = IDLE;
        else          cnt_adv  = 1'b1;
      end
      RD_ISSUE: state_nx = RD_WAIT;
      RD_WAIT:  state_nx = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (cnt_last) begin
            state_nx = IDLE;
          end else begin
            state_nx = RD_ISSUE;
            cnt_adv  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they line up with it;
  // Enable stays high through RD_WAIT because dropping it floats DataOut
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_en    <= MEM_EN_RST;
      mem_rw    <= MEM_RW_RST;
      mem_wdata <= MEM_WDATA_RST;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nx;
      mem_en    <= (state_nx == WRITE) || (state_nx == RD_ISSUE) || (state_nx == RD_WAIT);
      mem_rw    <= (state_nx != WRITE);
      rsp_valid <= (state_nx == RESP);
      rsp_last  <= (state_nx == RESP) && cnt_last;
      if (accept)           mem_wdata <= req_wdata;
      if (state == RD_WAIT) rsp_data  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed testbench for ram_access_ctrl with a behavioural 64x4 RAM attached to the mem pins.
module tb_ram_access_ctrl;
  import ram_ctrl_pkg::*;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  logic [DATA_W-1:0] ram [64];
  int                wr_count = 0;
  int                checks   = 0;
  int                errors   = 0;
  int                wr_base;

  ram_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: synchronous write, combinational read while enabled
  always @(posedge clk) begin
    if (mem_en && !mem_rw) begin
      ram[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
  end
  assign mem_rdata = (mem_en && mem_rw) ? ram[mem_addr] : 4'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic w, input int a, input int l, input int d);
    req_valid = v;
    req_write = w;
    req_addr  = ADDR_W'(a);
    req_len   = LEN_W'(l);
    req_wdata = DATA_W'(d);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doFill(input int a, input int l, input int d);
    applyStimulus(1'b1, 1'b1, a, l, d);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    repeat (l + 1) tick();
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 9, 2, 5);
    repeat (2) tick();

    $display("[TB] reset state with a request pending");
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_busy",      busy,      0);
    checkOutput("rst_mem_en",    mem_en,    0);
    checkOutput("rst_mem_rw",    mem_rw,    1);
    checkOutput("rst_mem_addr",  mem_addr,  0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_last",  rsp_last,  0);
    checkOutput("rst_rsp_data",  rsp_data,  0);
    checkOutput("rst_no_writes", wr_count,  0);
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", req_ready, 1);

    $display("[TB] fill addr=5 len=3 data=A");
    applyStimulus(1'b1, 1'b1, 5, 3, 4'hA);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("fill_en_%0d", i),    mem_en,    1);
      checkOutput($sformatf("fill_rw_%0d", i),    mem_rw,    0);
      checkOutput($sformatf("fill_addr_%0d", i),  mem_addr,  5 + i);
      checkOutput($sformatf("fill_wdata_%0d", i), mem_wdata, 4'hA);
      checkOutput($sformatf("fill_ready_%0d", i), req_ready, 0);
      tick();
    end
    checkOutput("fill_done_ready", req_ready, 1);
    checkOutput("fill_done_en",    mem_en,    0);
    checkOutput("fill_done_busy",  busy,      0);
    checkOutput("fill_wr_count",   wr_count,  4);
    for (int i = 5; i <= 8; i++)
      checkOutput($sformatf("fill_ram_%0d", i), ram[i], 4'hA);

    $display("[TB] request held during an active fill");
    applyStimulus(1'b1, 1'b1, 62, 0, 1);
    tick();
    applyStimulus(1'b1, 1'b1, 63, 0, 2);
    checkOutput("ovl_ready_busy", req_ready, 0);
    checkOutput("ovl_addr_62",    mem_addr,  62);
    checkOutput("ovl_wdata_1",    mem_wdata, 1);
    tick();
    checkOutput("ovl_ready_idle", req_ready, 1);
    checkOutput("ovl_idle_en",    mem_en,    0);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    checkOutput("ovl_taken_en",    mem_en,    1);
    checkOutput("ovl_taken_addr",  mem_addr,  63);
    checkOutput("ovl_taken_wdata", mem_wdata, 2);
    tick();
    doFill(0, 0, 3);
    doFill(1, 0, 4);
    checkOutput("wrap_ram_62", ram[62], 1);
    checkOutput("wrap_ram_1",  ram[1],  4);

    $display("[TB] read burst addr=62 len=3 across the wrap");
    applyStimulus(1'b1, 1'b0, 62, 3, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rd_issue_en_%0d", i),   mem_en,    1);
      checkOutput($sformatf("rd_issue_rw_%0d", i),   mem_rw,    1);
      checkOutput($sformatf("rd_issue_addr_%0d", i), mem_addr,  (62 + i) % 64);
      checkOutput($sformatf("rd_issue_vld_%0d", i),  rsp_valid, 0);
      tick();
      checkOutput($sformatf("rd_wait_en_%0d", i),    mem_en,    1);
      checkOutput($sformatf("rd_wait_addr_%0d", i),  mem_addr,  (62 + i) % 64);
      tick();
      checkOutput($sformatf("rd_resp_vld_%0d", i),   rsp_valid, 1);
      checkOutput($sformatf("rd_resp_data_%0d", i),  rsp_data,  i + 1);
      checkOutput($sformatf("rd_resp_last_%0d", i),  rsp_last,  (i == 3) ? 1 : 0);
      checkOutput($sformatf("rd_resp_en_%0d", i),    mem_en,    0);
      tick();
    end
    checkOutput("rd_done_vld",   rsp_valid, 0);
    checkOutput("rd_done_ready", req_ready, 1);

    $display("[TB] single read with response backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 7, 0, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp_vld_%0d", i),  rsp_valid, 1);
      checkOutput($sformatf("bp_data_%0d", i), rsp_data,  4'hA);
      checkOutput($sformatf("bp_last_%0d", i), rsp_last,  1);
      checkOutput($sformatf("bp_en_%0d", i),   mem_en,    0);
      checkOutput($sformatf("bp_busy_%0d", i), busy,      1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("bp_done_vld",   rsp_valid, 0);
    checkOutput("bp_done_ready", req_ready, 1);

    $display("[TB] reset during third beat of a 16-beat fill");
    doFill(0, 15, 3);
    wr_base = wr_count;
    applyStimulus(1'b1, 1'b1, 0, 15, 4'hC);
    tick();
    applyStimulus(1'b0, 1'b0, 0, 0, 0);
    tick();
    tick();
    checkOutput("mid_beat3_addr", mem_addr, 2);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_en",        mem_en,    0);
    checkOutput("mid_rst_rw",        mem_rw,    1);
    checkOutput("mid_rst_addr",      mem_addr,  0);
    checkOutput("mid_rst_wdata",     mem_wdata, 0);
    checkOutput("mid_rst_busy",      busy,      0);
    checkOutput("mid_rst_req_ready", req_ready, 0);
    checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    #1;
    checkOutput("mid_post_ready", req_ready, 1);
    repeat (3) tick();
    checkOutput("mid_wr_count", wr_count - wr_base, 3);
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("mid_ram_%0d", i), ram[i], (i < 3) ? 4'hC : 4'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Request-driven access sequencer sitting directly upstream of the 64x4 RAM_memory block. Accepts single or burst read/fill commands over a valid/ready request channel and drives the RAM's Enable/ReadWrite/Address/DataIn pins. Returns read data over a valid/ready response channel with backpressure. Upstream logic never touches RAM pins directly.

## Interface
- ADDR_W, 6, RAM address width (64 words)
- DATA_W, 4, RAM word width
- LEN_W, 4, burst length field width (beats = req_len+1, max 16)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  command accepted when valid&&ready
- req_write  in  1  1 = fill (write), 0 = read
- req_addr  in  ADDR_W  start address
- req_len  in  LEN_W  beats minus one
- req_wdata  in  DATA_W  fill value written to every beat
- rsp_valid  out  1  read word available
- rsp_ready  in  1  consumer takes word when valid&&ready
- rsp_data  out  DATA_W  read word
- rsp_last  out  1  final beat of the burst
- mem_en  out  1  to RAM Enable
- mem_rw  out  1  to RAM ReadWrite (1 = read, 0 = write)
- mem_addr  out  ADDR_W  to RAM Address
- mem_wdata  out  DATA_W  to RAM DataIn
- mem_rdata  in  DATA_W  from RAM DataOut
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP.
- IDLE: req_ready=1 (0 while rst high). On accept, latch addr, len, wdata, write; go WRITE if req_write else RD_ISSUE.
- WRITE: mem_en=1, mem_rw=0, mem_addr=current, mem_wdata=latched value; one beat per cycle; after beat count reaches len, return to IDLE.
- RD_ISSUE: mem_en=1, mem_rw=1, mem_addr=current; next state RD_WAIT.
- RD_WAIT: hold mem_en=1, mem_rw=1, mem_addr unchanged (dropping Enable tri-states RAM output); capture mem_rdata into rsp_data at clock end; go RESP.
- RESP: mem_en=0; rsp_valid=1, rsp_last=1 on final beat; rsp_data stable until handshake. On rsp_valid&&rsp_ready: if last, IDLE; else increment addr, RD_ISSUE.
- Address increment is modulo 2^ADDR_W: 63 -> 0, no error.
- Beat counter LEN_W bits, counts 0..len; len=15 gives 16 beats.
- New requests are never accepted while busy; no queueing.

## Timing
- Reset values: req_ready 0 during reset, rsp_valid 0, rsp_last 0, rsp_data 0, mem_en 0, mem_rw 1, mem_addr 0, mem_wdata 0, busy 0.
- All outputs except req_ready and busy are registered; req_ready/busy decode state.
- Fill: first RAM write in cycle after accept; N beats occupy N consecutive cycles; req_ready returns the cycle after last write.
- Read: accept at edge T; RD_ISSUE cycle T+1, RD_WAIT T+2, rsp_valid high from T+3. Minimum 3 cycles per beat with rsp_ready held high.
- rsp_ready low: stay in RESP indefinitely; rsp_data, rsp_last stable; mem_en stays 0.
- rst asserted mid-burst: next edge forces IDLE and reset values; remaining beats abandoned, no further RAM writes, pending response dropped.
- req_valid and rst high together: request ignored.

## Structure
- Package ram_ctrl_pkg: ADDR_W, DATA_W, LEN_W constants; state enum type; reset constants for mem outputs.
- One sub-module: burst_counter (loadable address counter with wrap plus beat counter, outputs last flag), instantiated once.

## Test plan
- Fill addr=5, len=3, wdata=4'hA -> writes at 5,6,7,8 on 4 consecutive cycles, mem_rw=0; RAM words 5..8 read back 4'hA.
- Read addr=62, len=3 after fill of 62,63,0,1 with 1,2,3,4 -> rsp_data 1,2,3,4, rsp_last only on 4th; addresses wrap 63->0.
- Read len=0 with rsp_ready held low 10 cycles -> rsp_valid stays 1, data stable, mem_en 0, single beat after ready.
- req_valid asserted during active burst -> req_ready 0, command not taken until IDLE; then accepted cycle after burst ends.
- rst asserted during 3rd beat of 16-beat fill at addr 0 -> only words 0..2 modified, all outputs at reset values next cycle, req_ready 1 after rst drops.
